// File: rtl/snake_pkg.sv
// Shared constants, coordinate widths and the apple spawner state encoding
// used across the snake game datapath.
package snake_pkg;

  localparam int CELL         = 10;
  localparam int GRID_W       = 64;
  localparam int GRID_H       = 48;
  localparam int MAX_LEN      = 33;
  localparam int BORDER_CELLS = 1;
  localparam int MAX_TRIES    = 16;
  localparam int INIT_CX      = 40;
  localparam int INIT_CY      = 24;

  localparam int X_W   = 10;
  localparam int Y_W   = 9;
  localparam int LEN_W = $clog2(MAX_LEN + 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRAW   = 2'd1,
    ST_SCAN   = 2'd2,
    ST_COMMIT = 2'd3
  } spawn_state_e;

endpackage

// File: rtl/bus_segment_mux.sv
// Combinational slice-select: returns {x, y} of segment idx from the packed
// body buses; out-of-range indices return zero.
module bus_segment_mux
  import snake_pkg::*;
#(
  parameter int N     = MAX_LEN,
  parameter int IDX_W = LEN_W
) (
  input  logic [N*X_W-1:0]     bus_x,
  input  logic [N*Y_W-1:0]     bus_y,
  input  logic [IDX_W-1:0]     idx,
  output logic [X_W+Y_W-1:0]   seg
);

  logic [X_W-1:0] xs [N];
  logic [Y_W-1:0] ys [N];

  for (genvar g = 0; g < N; g++) begin : g_slice
    assign xs[g] = bus_x[g*X_W +: X_W];
    assign ys[g] = bus_y[g*Y_W +: Y_W];
  end

  always_comb begin
    seg = '0;
    if (int'(idx) < N) seg = {xs[idx], ys[idx]};
  end

endmodule

// File: rtl/apple_spawner.sv
// Places the apple on a free, non-border grid cell after each eat event,
// checking candidates serially against a snapshot of the snake body.
module apple_spawner #(
  parameter int CELL         = 10,
  parameter int GRID_W       = 64,
  parameter int GRID_H       = 48,
  parameter int MAX_LEN      = 33,
  parameter int BORDER_CELLS = 1,
  parameter int MAX_TRIES    = 16,
  parameter int INIT_CX      = 40,
  parameter int INIT_CY      = 24
) (
  input  logic                  clk_pix,
  input  logic                  reset_n,
  input  logic                  eat_evt,
  input  logic [15:0]           rnd,
  input  logic [7:0]            snake_len,
  input  logic [MAX_LEN*10-1:0] body_bus_x,
  input  logic [MAX_LEN*9-1:0]  body_bus_y,
  output logic [9:0]            apple_x,
  output logic [8:0]            apple_y,
  output logic                  apple_valid,
  output logic                  busy
);

  import snake_pkg::*;

  localparam int LW = $clog2(MAX_LEN + 1);
  localparam int TW = $clog2(MAX_TRIES + 1);

  localparam logic [6:0]    X_LO      = 7'(BORDER_CELLS);
  localparam logic [6:0]    X_HI      = 7'(GRID_W - 1 - BORDER_CELLS);
  localparam logic [6:0]    Y_LO      = 7'(BORDER_CELLS);
  localparam logic [6:0]    Y_HI      = 7'(GRID_H - 1 - BORDER_CELLS);
  localparam logic [9:0]    CELL_X    = 10'(CELL);
  localparam logic [8:0]    CELL_Y    = 9'(CELL);
  localparam logic [9:0]    INIT_X    = 10'(INIT_CX * CELL);
  localparam logic [8:0]    INIT_Y    = 9'(INIT_CY * CELL);
  localparam logic [7:0]    LEN_MAX8  = 8'(MAX_LEN);
  localparam logic [LW-1:0] LEN_MAX   = LW'(MAX_LEN);
  localparam logic [LW-1:0] LEN_ONE   = LW'(1);
  localparam logic [TW-1:0] TRIES_MAX = TW'(MAX_TRIES);

  spawn_state_e state_q, state_d;

  logic [TW-1:0]           tries_q, tries_d;
  logic [5:0]              cx_q, cx_d;
  logic [5:0]              cy_q, cy_d;
  logic [LW-1:0]           idx_q, idx_d;
  logic [LW-1:0]           len_q, len_d;
  logic [MAX_LEN*10-1:0]   snap_x_q, snap_x_d;
  logic [MAX_LEN*9-1:0]    snap_y_q, snap_y_d;
  logic [9:0]              apple_x_q, apple_x_d;
  logic [8:0]              apple_y_q, apple_y_d;
  logic                    valid_q, valid_d;
  logic                    busy_q, busy_d;

  logic [LW-1:0]           len_clamp;
  logic [9:0]              cand_x;
  logic [8:0]              cand_y;
  logic [18:0]             seg;
  logic                    seg_hit;
  logic [6:0]              rnd_cx, rnd_cy;
  logic [6:0]              sweep_cx, sweep_cy;

  bus_segment_mux #(
    .N     (MAX_LEN),
    .IDX_W (LW)
  ) u_seg_mux (
    .bus_x (snap_x_q),
    .bus_y (snap_y_q),
    .idx   (idx_q),
    .seg   (seg)
  );

  assign cand_x  = {4'b0, cx_q} * CELL_X;
  assign cand_y  = {3'b0, cy_q} * CELL_Y;
  assign seg_hit = (seg[18:9] == cand_x) && (seg[8:0] == cand_y);
  assign rnd_cx  = {1'b0, rnd[5:0]};
  assign rnd_cy  = {1'b0, rnd[11:6]};

  always_comb begin
    len_clamp = LEN_MAX;
    if (snake_len == 8'd0)          len_clamp = LEN_ONE;
    else if (snake_len < LEN_MAX8)  len_clamp = snake_len[LW-1:0];
  end

  // Raster step from the previous candidate; a candidate left on a border
  // row by a rejected random draw is pulled back into the playfield.
  always_comb begin
    sweep_cx = {1'b0, cx_q} + 7'd1;
    sweep_cy = {1'b0, cy_q};
    if (sweep_cx > X_HI) begin
      sweep_cx = X_LO;
      sweep_cy = sweep_cy + 7'd1;
    end
    if ((sweep_cy > Y_HI) || (sweep_cy < Y_LO)) sweep_cy = Y_LO;
  end

  always_comb begin
    state_d   = state_q;
    tries_d   = tries_q;
    cx_d      = cx_q;
    cy_d      = cy_q;
    idx_d     = idx_q;
    len_d     = len_q;
    snap_x_d  = snap_x_q;
    snap_y_d  = snap_y_q;
    apple_x_d = apple_x_q;
    apple_y_d = apple_y_q;
    valid_d   = valid_q;
    busy_d    = busy_q;
    case (state_q)
      ST_IDLE: begin
        if (eat_evt) begin
          snap_x_d = body_bus_x;
          snap_y_d = body_bus_y;
          len_d    = len_clamp;
          tries_d  = '0;
          valid_d  = 1'b0;
          busy_d   = 1'b1;
          state_d  = ST_DRAW;
        end
      end
      ST_DRAW: begin
        if (tries_q < TRIES_MAX) begin
          cx_d = rnd[5:0];
          cy_d = rnd[11:6];
          if ((rnd_cx < X_LO) || (rnd_cx > X_HI) ||
              (rnd_cy < Y_LO) || (rnd_cy > Y_HI)) begin
            tries_d = tries_q + 1'b1;
          end else begin
            idx_d   = '0;
            state_d = ST_SCAN;
          end
        end else begin
          cx_d    = sweep_cx[5:0];
          cy_d    = sweep_cy[5:0];
          idx_d   = '0;
          state_d = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (seg_hit) begin
          if (tries_q != TRIES_MAX) tries_d = tries_q + 1'b1;
          state_d = ST_DRAW;
        end else if (idx_q == len_q - LEN_ONE) begin
          state_d = ST_COMMIT;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      ST_COMMIT: begin
        apple_x_d = cand_x;
        apple_y_d = cand_y;
        valid_d   = 1'b1;
        busy_d    = 1'b0;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_pix) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      tries_q   <= '0;
      cx_q      <= '0;
      cy_q      <= '0;
      idx_q     <= '0;
      len_q     <= LEN_ONE;
      apple_x_q <= INIT_X;
      apple_y_q <= INIT_Y;
      valid_q   <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      tries_q   <= tries_d;
      cx_q      <= cx_d;
      cy_q      <= cy_d;
      idx_q     <= idx_d;
      len_q     <= len_d;
      apple_x_q <= apple_x_d;
      apple_y_q <= apple_y_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
    end
  end

  // Snapshot is only meaningful while busy, so it carries no reset.
  always_ff @(posedge clk_pix) begin
    snap_x_q <= snap_x_d;
    snap_y_q <= snap_y_d;
  end

  assign apple_x     = apple_x_q;
  assign apple_y     = apple_y_q;
  assign apple_valid = valid_q;
  assign busy        = busy_q;

endmodule
